// File: rtl/add_rs_dispatch.sv
// Reservation station for the integer add/sub units: holds issued instructions,
// snoops the CDB for missing operands and dispatches ready entries to free adders.
module add_rs_dispatch #(
  parameter int ENTRIES = 3,
  parameter int NUM_ADD = 3,
  parameter int XLEN    = 32,
  parameter int TAGW    = 3
) (
  input  logic                         clk1,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         iss_valid,
  output logic                         iss_ready,
  input  logic [6:0]                   iss_fun7,
  input  logic [TAGW-1:0]              iss_des,
  input  logic [XLEN-1:0]              iss_v1,
  input  logic [XLEN-1:0]              iss_v2,
  input  logic                         iss_rdy1,
  input  logic                         iss_rdy2,
  input  logic [TAGW-1:0]              iss_tag1,
  input  logic [TAGW-1:0]              iss_tag2,
  input  logic                         cdb_valid,
  input  logic [TAGW-1:0]              cdb_tag,
  input  logic [XLEN-1:0]              cdb_data,
  input  logic [NUM_ADD-1:0]           add_free,
  output logic [NUM_ADD-1:0]           disp_fla,
  output logic [NUM_ADD*XLEN-1:0]      disp_data1,
  output logic [NUM_ADD*XLEN-1:0]      disp_data2,
  output logic [NUM_ADD*TAGW-1:0]      disp_des,
  output logic [NUM_ADD*7-1:0]         disp_fun7,
  output logic [$clog2(ENTRIES+1)-1:0] occupancy
);

  localparam int IDXW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int OCCW = $clog2(ENTRIES+1);

  logic [ENTRIES-1:0] busy;
  logic [ENTRIES-1:0] rdy1;
  logic [ENTRIES-1:0] rdy2;
  logic [6:0]         fun7_q [ENTRIES];
  logic [TAGW-1:0]    des_q  [ENTRIES];
  logic [TAGW-1:0]    tag1_q [ENTRIES];
  logic [TAGW-1:0]    tag2_q [ENTRIES];
  logic [XLEN-1:0]    v1_q   [ENTRIES];
  logic [XLEN-1:0]    v2_q   [ENTRIES];

  logic [ENTRIES-1:0] eligible;
  logic [ENTRIES-1:0] hit1;
  logic [ENTRIES-1:0] hit2;
  logic [ENTRIES-1:0] taken;
  logic [ENTRIES-1:0] issue_sel;
  logic [NUM_ADD-1:0] pair_valid;
  logic [IDXW-1:0]    pair_idx [NUM_ADD];
  logic [IDXW-1:0]    free_idx;
  logic [OCCW-1:0]    disp_cnt;
  logic               issue_fire;
  logic               byp1;
  logic               byp2;

  assign iss_ready  = ~&busy;
  assign issue_fire = iss_valid & iss_ready;
  assign byp1       = ~iss_rdy1 & cdb_valid & (iss_tag1 == cdb_tag);
  assign byp2       = ~iss_rdy2 & cdb_valid & (iss_tag2 == cdb_tag);

  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDXW'(i);
    end
  end

  always_comb begin
    issue_sel = '0;
    eligible  = '0;
    hit1      = '0;
    hit2      = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      issue_sel[i] = issue_fire && (free_idx == IDXW'(i));
      eligible[i]  = busy[i] & rdy1[i] & rdy2[i];
      hit1[i]      = busy[i] & ~rdy1[i] & cdb_valid & (tag1_q[i] == cdb_tag);
      hit2[i]      = busy[i] & ~rdy2[i] & cdb_valid & (tag2_q[i] == cdb_tag);
    end
  end

  // Walk free adders in ascending order, each grabbing the lowest eligible entry not yet taken.
  always_comb begin
    pair_valid = '0;
    taken      = '0;
    disp_cnt   = '0;
    for (int k = 0; k < NUM_ADD; k++) begin
      pair_idx[k] = '0;
      if (add_free[k]) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (!pair_valid[k] && eligible[i] && !taken[i]) begin
            pair_valid[k] = 1'b1;
            pair_idx[k]   = IDXW'(i);
            taken[i]      = 1'b1;
          end
        end
      end
      disp_cnt = disp_cnt + OCCW'(pair_valid[k]);
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n || flush) begin
      busy      <= '0;
      occupancy <= '0;
      disp_fla  <= '0;
    end else begin
      disp_fla  <= pair_valid;
      occupancy <= occupancy + OCCW'(issue_fire) - disp_cnt;
      for (int i = 0; i < ENTRIES; i++) begin
        if (issue_sel[i]) begin
          busy[i] <= 1'b1;
          rdy1[i] <= iss_rdy1 | byp1;
          rdy2[i] <= iss_rdy2 | byp2;
        end else begin
          if (taken[i]) busy[i] <= 1'b0;
          if (hit1[i])  rdy1[i] <= 1'b1;
          if (hit2[i])  rdy2[i] <= 1'b1;
        end
      end
    end
  end

  // Payload needs no reset: it is only observed while the matching busy bit is set.
  always_ff @(posedge clk1) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (issue_sel[i]) begin
        fun7_q[i] <= iss_fun7;
        des_q[i]  <= iss_des;
        tag1_q[i] <= iss_tag1;
        tag2_q[i] <= iss_tag2;
        v1_q[i]   <= iss_rdy1 ? iss_v1 : cdb_data;
        v2_q[i]   <= iss_rdy2 ? iss_v2 : cdb_data;
      end else begin
        if (hit1[i]) v1_q[i] <= cdb_data;
        if (hit2[i]) v2_q[i] <= cdb_data;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      disp_data1 <= '0;
      disp_data2 <= '0;
      disp_des   <= '0;
      disp_fun7  <= '0;
    end else if (!flush) begin
      for (int k = 0; k < NUM_ADD; k++) begin
        if (pair_valid[k]) begin
          disp_data1[k*XLEN +: XLEN] <= v1_q[pair_idx[k]];
          disp_data2[k*XLEN +: XLEN] <= v2_q[pair_idx[k]];
          disp_des[k*TAGW +: TAGW]   <= des_q[pair_idx[k]];
          disp_fun7[k*7 +: 7]        <= fun7_q[pair_idx[k]];
        end
      end
    end
  end

endmodule

// File: tb/tb_add_rs_dispatch.sv
// Scoreboard bench for add_rs_dispatch: expected dispatches are queued with their
// cycle and adder when stimulus is driven, then popped as disp_fla pulses appear.
module tb_add_rs_dispatch;

  localparam int ENTRIES = 3;
  localparam int NUM_ADD = 3;
  localparam int XLEN    = 32;
  localparam int TAGW    = 3;
  localparam logic [6:0] F_ADD = 7'b0000000;
  localparam logic [6:0] F_SUB = 7'b0100000;

  logic                    clk1;
  logic                    rst_n;
  logic                    flush;
  logic                    iss_valid;
  logic                    iss_ready;
  logic [6:0]              iss_fun7;
  logic [TAGW-1:0]         iss_des;
  logic [XLEN-1:0]         iss_v1;
  logic [XLEN-1:0]         iss_v2;
  logic                    iss_rdy1;
  logic                    iss_rdy2;
  logic [TAGW-1:0]         iss_tag1;
  logic [TAGW-1:0]         iss_tag2;
  logic                    cdb_valid;
  logic [TAGW-1:0]         cdb_tag;
  logic [XLEN-1:0]         cdb_data;
  logic [NUM_ADD-1:0]      add_free;
  logic [NUM_ADD-1:0]      disp_fla;
  logic [NUM_ADD*XLEN-1:0] disp_data1;
  logic [NUM_ADD*XLEN-1:0] disp_data2;
  logic [NUM_ADD*TAGW-1:0] disp_des;
  logic [NUM_ADD*7-1:0]    disp_fun7;
  logic [1:0]              occupancy;

  typedef struct {
    int              cyc;
    int              adder;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [TAGW-1:0] des;
    logic [6:0]      fun7;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   assertions = 0;
  int   failures = 0;

  add_rs_dispatch #(.ENTRIES(ENTRIES), .NUM_ADD(NUM_ADD), .XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_fun7(iss_fun7), .iss_des(iss_des),
    .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_rdy1(iss_rdy1), .iss_rdy2(iss_rdy2),
    .iss_tag1(iss_tag1), .iss_tag2(iss_tag2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .add_free(add_free), .disp_fla(disp_fla), .disp_data1(disp_data1), .disp_data2(disp_data2),
    .disp_des(disp_des), .disp_fun7(disp_fun7), .occupancy(occupancy)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  always @(posedge clk1) cyc = cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertions++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic pushExp(input int c, input int a, input logic [XLEN-1:0] d1,
                         input logic [XLEN-1:0] d2, input logic [TAGW-1:0] des,
                         input logic [6:0] f);
    exp_t e;
    e.cyc = c; e.adder = a; e.d1 = d1; e.d2 = d2; e.des = des; e.fun7 = f;
    sbq.push_back(e);
  endtask

  task automatic applyStimulus(input logic [6:0] f, input logic [TAGW-1:0] des,
                               input logic [XLEN-1:0] v1, input logic r1, input logic [TAGW-1:0] t1,
                               input logic [XLEN-1:0] v2, input logic r2, input logic [TAGW-1:0] t2);
    iss_valid = 1'b1;
    iss_fun7 = f; iss_des = des;
    iss_v1 = v1; iss_rdy1 = r1; iss_tag1 = t1;
    iss_v2 = v2; iss_rdy2 = r2; iss_tag2 = t2;
    tick();
    iss_valid = 1'b0;
  endtask

  // Every pulse must match the head of the scoreboard, in ascending adder order.
  always @(negedge clk1) begin
    if (rst_n) begin
      for (int k = 0; k < NUM_ADD; k++) begin
        if (disp_fla[k]) begin
          if (sbq.size() == 0) begin
            checkOutput("unexpected_fla", 64'(k + 1), 64'd0);
          end else begin
            mon_e = sbq.pop_front();
            checkOutput("disp_cycle", 64'(cyc), 64'(mon_e.cyc));
            checkOutput("disp_adder", 64'(k), 64'(mon_e.adder));
            checkOutput("disp_data1", 64'(disp_data1[k*XLEN +: XLEN]), 64'(mon_e.d1));
            checkOutput("disp_data2", 64'(disp_data2[k*XLEN +: XLEN]), 64'(mon_e.d2));
            checkOutput("disp_des", 64'(disp_des[k*TAGW +: TAGW]), 64'(mon_e.des));
            checkOutput("disp_fun7", 64'(disp_fun7[k*7 +: 7]), 64'(mon_e.fun7));
          end
        end
      end
    end
  end

  initial begin
    int c;
    rst_n = 1'b0; flush = 1'b0; iss_valid = 1'b0;
    iss_fun7 = '0; iss_des = '0; iss_v1 = '0; iss_v2 = '0;
    iss_rdy1 = 1'b0; iss_rdy2 = 1'b0; iss_tag1 = '0; iss_tag2 = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; add_free = 3'b111;
    tick(); tick();
    rst_n = 1'b1;
    checkOutput("rst_iss_ready", 64'(iss_ready), 64'd1);
    checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
    checkOutput("rst_fla", 64'(disp_fla), 64'd0);
    checkOutput("rst_data1", 64'(disp_data1[31:0]), 64'd0);
    checkOutput("rst_fun7", 64'(disp_fun7), 64'd0);
    tick();

    $display("[TB] ready add dispatches one cycle after issue");
    pushExp(cyc + 2, 0, 32'd5, 32'd7, 3'd2, F_ADD);
    applyStimulus(F_ADD, 3'd2, 32'd5, 1'b1, 3'd0, 32'd7, 1'b1, 3'd0);
    checkOutput("t1_occ_issued", 64'(occupancy), 64'd1);
    tick();
    checkOutput("t1_occ_after", 64'(occupancy), 64'd0);
    tick();

    $display("[TB] sub waits on tag 4 then wakes from the CDB");
    applyStimulus(F_SUB, 3'd3, 32'd0, 1'b0, 3'd4, 32'd3, 1'b1, 3'd0);
    checkOutput("t2_occ_wait", 64'(occupancy), 64'd1);
    tick();
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 32'd20;
    pushExp(cyc + 2, 0, 32'd20, 32'd3, 3'd3, F_SUB);
    tick();
    cdb_valid = 1'b0;
    checkOutput("t2_occ_captured", 64'(occupancy), 64'd1);
    tick();
    checkOutput("t2_occ_after", 64'(occupancy), 64'd0);

    $display("[TB] three ready entries against a partial free mask");
    add_free = 3'b000;
    applyStimulus(F_ADD, 3'd1, 32'd10, 1'b1, 3'd0, 32'd11, 1'b1, 3'd0);
    applyStimulus(F_SUB, 3'd2, 32'd20, 1'b1, 3'd0, 32'd21, 1'b1, 3'd0);
    applyStimulus(7'b1111111, 3'd3, 32'd30, 1'b1, 3'd0, 32'd31, 1'b1, 3'd0);
    checkOutput("t3_occ_full", 64'(occupancy), 64'd3);
    checkOutput("t3_ready_full", 64'(iss_ready), 64'd0);
    add_free = 3'b101;
    pushExp(cyc + 1, 0, 32'd10, 32'd11, 3'd1, F_ADD);
    pushExp(cyc + 1, 2, 32'd20, 32'd21, 3'd2, F_SUB);
    tick();
    checkOutput("t3_occ_pair", 64'(occupancy), 64'd1);
    add_free = 3'b010;
    pushExp(cyc + 1, 1, 32'd30, 32'd31, 3'd3, 7'b1111111);
    tick();
    add_free = 3'b111;
    checkOutput("t3_occ_after", 64'(occupancy), 64'd0);
    tick();

    $display("[TB] full station holds a fourth issue until a slot frees");
    applyStimulus(F_ADD, 3'd4, 32'd0, 1'b0, 3'd5, 32'd1, 1'b1, 3'd0);
    applyStimulus(F_SUB, 3'd5, 32'd0, 1'b0, 3'd6, 32'd2, 1'b1, 3'd0);
    applyStimulus(F_ADD, 3'd6, 32'd0, 1'b0, 3'd7, 32'd3, 1'b1, 3'd0);
    checkOutput("t4_ready_full", 64'(iss_ready), 64'd0);
    iss_valid = 1'b1; iss_fun7 = F_ADD; iss_des = 3'd7;
    iss_v1 = 32'd11; iss_rdy1 = 1'b1; iss_v2 = 32'd22; iss_rdy2 = 1'b1;
    tick();
    checkOutput("t4_occ_held", 64'(occupancy), 64'd3);
    checkOutput("t4_ready_held", 64'(iss_ready), 64'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 32'd100;
    pushExp(cyc + 2, 0, 32'd100, 32'd2, 3'd5, F_SUB);
    tick();
    cdb_valid = 1'b0;
    checkOutput("t4_ready_wake", 64'(iss_ready), 64'd0);
    tick();
    checkOutput("t4_ready_freed", 64'(iss_ready), 64'd1);
    checkOutput("t4_occ_freed", 64'(occupancy), 64'd2);
    pushExp(cyc + 2, 0, 32'd11, 32'd22, 3'd7, F_ADD);
    tick();
    iss_valid = 1'b0;
    checkOutput("t4_occ_refill", 64'(occupancy), 64'd3);
    tick();
    checkOutput("t4_occ_after", 64'(occupancy), 64'd2);

    $display("[TB] flush with concurrent issue and CDB hit");
    flush = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 32'd50;
    iss_valid = 1'b1; iss_fun7 = F_ADD; iss_des = 3'd1;
    iss_v1 = 32'd1; iss_rdy1 = 1'b1; iss_v2 = 32'd1; iss_rdy2 = 1'b1;
    tick();
    flush = 1'b0; iss_valid = 1'b0;
    checkOutput("t6_occ_flush", 64'(occupancy), 64'd0);
    checkOutput("t6_ready_flush", 64'(iss_ready), 64'd1);
    cdb_tag = 3'd7; cdb_data = 32'd70;
    tick();
    cdb_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("t6_occ_idle", 64'(occupancy), 64'd0);
    checkOutput("t6_des_hold", 64'(disp_des[TAGW-1:0]), 64'd7);
    checkOutput("t6_data1_hold", 64'(disp_data1[XLEN-1:0]), 64'd11);

    $display("[TB] issue-time bypass from the CDB");
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 32'd9;
    pushExp(cyc + 2, 0, 32'd9, 32'd4, 3'd1, F_ADD);
    applyStimulus(F_ADD, 3'd1, 32'hDEAD, 1'b0, 3'd6, 32'd4, 1'b1, 3'd0);
    cdb_valid = 1'b0;
    tick();
    checkOutput("t5_occ_after", 64'(occupancy), 64'd0);

    c = 0;
    while (sbq.size() != 0 && c < 20) begin
      tick();
      c++;
    end
    checkOutput("sb_drain", 64'(sbq.size()), 64'd0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("rst2_data1", 64'(disp_data1[XLEN-1:0]), 64'd0);
    checkOutput("rst2_des", 64'(disp_des), 64'd0);
    checkOutput("rst2_ready", 64'(iss_ready), 64'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/add_rs_dispatch.md
# add_rs_dispatch

Reservation station for the integer add/sub functional units in the Tomasulo core. It accepts decoded add-class instructions from the issue stage and holds them until both operands are valid. Operands arrive either with the instruction or later from the common data bus (CDB). It then dispatches each ready entry to a free adder, driving that adder's `data1`/`data2`/`des`/`fun7`/`fla` inputs. It sits directly upstream of the adder units and replaces the shared `RSadd*` arrays as the single owner of add-station state.

## Interface
Parameters:
- `ENTRIES`, 3: station depth.
- `NUM_ADD`, 3: number of adder units served.
- `XLEN`, 32: operand width.
- `TAGW`, 3: ROB tag width.

Ports:
- `clk1`  in  1  the only clock; all state updates on its rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `flush`  in  1  synchronous clear of all entries (mispredict/exception).
- `iss_valid` / `iss_ready`  in/out  1  issue handshake; transfer when both high at the edge.
- `iss_fun7`  in  7  `0000000` = add, `0100000` = sub.
- `iss_des`  in  TAGW  destination ROB tag.
- `iss_v1`, `iss_v2`  in  XLEN  operand values (meaningful only when ready).
- `iss_rdy1`, `iss_rdy2`  in  1  operand already valid.
- `iss_tag1`, `iss_tag2`  in  TAGW  producing ROB tag when not ready.
- `cdb_valid`  in  1  result broadcast this cycle.
- `cdb_tag`  in  TAGW  ROB tag of the broadcast result.
- `cdb_data`  in  XLEN  value of the broadcast result.
- `add_free`  in  NUM_ADD  bit k = adder k can accept work.
- `disp_fla`  out  NUM_ADD  one-cycle start pulse per adder.
- `disp_data1`, `disp_data2`  out  NUM_ADD*XLEN  packed operands; adder k uses slice k.
- `disp_des`  out  NUM_ADD*TAGW  packed destination tags.
- `disp_fun7`  out  NUM_ADD*7  packed opcodes.
- `occupancy`  out  $clog2(ENTRIES+1)  number of valid entries.

## Operation
- Entry state: `busy`, `fun7`, `des`, `v1`/`rdy1`/`tag1`, `v2`/`rdy2`/`tag2`.
- `iss_ready` = at least one entry not busy, computed from registered state only. An entry freed by dispatch in cycle N is not reusable until cycle N+1.
- Issue writes the lowest-index free entry.
- Issue-time bypass: if `cdb_valid` and `cdb_tag` equals a not-ready `iss_tagX` in the same cycle, the entry stores `cdb_data` with ready=1.
- Snoop: every busy entry with `rdyX=0` and `tagX==cdb_tag` while `cdb_valid` captures `cdb_data` and sets `rdyX=1`. Both operands of one entry may match the same broadcast.
- Dispatch eligibility: busy, `rdy1 & rdy2`, both as registered at the start of the cycle. There is no CDB-to-dispatch bypass.
- Pairing: eligible entries in ascending index order are matched to set bits of `add_free` in ascending order. Up to min(eligible, free) dispatches happen per cycle.
- At the edge, each paired adder k gets its `disp_*` slice loaded, `disp_fla[k]`=1, and the source entry cleared.
- Unpaired adders get `disp_fla[k]`=0 and their `disp_*` slice holds its last value.
- `fun7` is forwarded unchanged; codes other than add/sub are not filtered.
- `flush` and `!rst_n` clear all busy bits, `disp_fla`, and `occupancy`. Both override issue, snoop and dispatch in the same cycle. `rst_n` also zeroes all `disp_*` registers.
- `occupancy` = previous value + issue − dispatches. Its range is 0..ENTRIES.

## Timing
- Reset values: `iss_ready`=1 (after the reset edge), `disp_fla`=0, `disp_data1`/`disp_data2`/`disp_des`/`disp_fun7`=0, `occupancy`=0.
- Issue at edge N with both operands ready: `disp_fla` is high during cycle N+1, if an adder is free at edge N+1.
- Operand captured from the CDB at edge N: earliest dispatch is edge N+1.
- `disp_fla` is a single-cycle pulse; a new dispatch to the same adder needs `add_free[k]` high again.
- Full station: `iss_ready`=0. An issue attempt is held by the upstream stage with no state change.
- Simultaneous issue and dispatch when full: the issue is not accepted that cycle.

## Test plan
- Reset then issue add, v1=5, v2=7, both ready, des=2, `add_free`=3'b111: `disp_fla`=3'b001 one cycle later; slice 0 = 5, 7, des 2, fun7 0; `occupancy` back to 0.
- Issue sub with op1 waiting on tag 4, then CDB {tag 4, data 20} two cycles later, v2=3: dispatch occurs exactly one cycle after the broadcast with data1=20, `disp_fun7` slice = `0100000`.
- Three ready entries, `add_free`=3'b101: entries 0 and 1 go to adders 0 and 2 in one cycle; entry 2 goes to the first adder freed later.
- Fill all 3 entries with operands not ready: `iss_ready`=0, a fourth issue is held, and `occupancy`=3. One CDB wakeup then dispatch: `iss_ready`=1 the following cycle.
- Issue with `iss_tag1`=6 in the same cycle as CDB {tag 6, data 9}: the entry captures 9 and dispatches the next cycle.
- Two entries pending, assert `flush` together with an issue and a CDB hit: all entries cleared, `occupancy`=0, no `disp_fla` afterward.
